// File: rtl/vx_axi_mem_responder.sv
// AXI4 slave backed by a word-addressed memory.
// One write and one read burst in flight, INCR only.
module vx_axi_mem_responder #(
    parameter int AXI_DATA_WIDTH = 512,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_TID_WIDTH  = 8,
    parameter int MEM_DEPTH_W    = 10,
    parameter int READ_LATENCY   = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [AXI_TID_WIDTH-1:0]    s_axi_awid,
    input  logic [7:0]                  s_axi_awlen,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    output logic [AXI_TID_WIDTH-1:0]    s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [AXI_TID_WIDTH-1:0]    s_axi_arid,
    input  logic [7:0]                  s_axi_arlen,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                        s_axi_rlast,
    output logic [AXI_TID_WIDTH-1:0]    s_axi_rid,
    output logic [1:0]                  s_axi_rresp
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IDX_W  = AXI_ADDR_WIDTH + 1;
    localparam int DEPTH  = 1 << MEM_DEPTH_W;
    localparam logic [3:0] LAT_INIT =
        (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] { W_IDLE, W_DATA, W_RESP } w_state_t;
    typedef enum logic [1:0] { R_IDLE, R_WAIT, R_DATA } r_state_t;

    logic [AXI_DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic             run;
    w_state_t         w_state;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_beat;
    logic [7:0]       w_len;
    logic             w_err;
    r_state_t         r_state;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_beat;
    logic [7:0]       r_len;
    logic [3:0]       lat_cnt;

    logic                      aw_fire, w_fire, ar_fire;
    logic [IDX_W-1:0]          aw_idx, ar_idx;
    logic                      w_ok, w_last, beat_err;
    logic                      r_load, ld_ok;
    logic [IDX_W-1:0]          ld_idx;
    logic [7:0]                ld_beat, ld_len;
    logic [AXI_DATA_WIDTH-1:0] ld_data;

    // Accepts are held off until one clock edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) run <= 1'b0;
        else          run <= 1'b1;
    end

    assign aw_fire  = s_axi_awvalid && s_axi_awready && run;
    assign ar_fire  = s_axi_arvalid && s_axi_arready && run;
    assign w_fire   = s_axi_wvalid && s_axi_wready;
    assign aw_idx   = {1'b0, s_axi_awaddr} >> OFF;
    assign ar_idx   = {1'b0, s_axi_araddr} >> OFF;
    assign w_ok     = (w_idx[IDX_W-1:MEM_DEPTH_W] == '0);
    assign w_last   = (w_beat == w_len);
    assign beat_err = !w_ok || (s_axi_wlast != w_last);

    always_ff @(posedge clk) begin
        if (w_fire && w_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b])
                    mem[w_idx[MEM_DEPTH_W-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_state       <= W_IDLE;
            w_idx         <= '0;
            w_beat        <= '0;
            w_len         <= '0;
            w_err         <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= 2'b00;
        end else begin
            unique case (w_state)
                W_IDLE: if (aw_fire) begin
                    s_axi_bid     <= s_axi_awid;
                    w_len         <= s_axi_awlen;
                    w_idx         <= aw_idx;
                    w_beat        <= '0;
                    w_err         <= 1'b0;
                    s_axi_awready <= 1'b0;
                    s_axi_wready  <= 1'b1;
                    w_state       <= W_DATA;
                end
                W_DATA: if (w_fire) begin
                    if (w_last) begin
                        s_axi_wready <= 1'b0;
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= (w_err || beat_err) ? 2'b10 : 2'b00;
                        w_state      <= W_RESP;
                    end else begin
                        w_beat <= w_beat + 8'd1;
                        w_idx  <= w_idx + IDX_W'(1);
                        w_err  <= w_err || beat_err;
                    end
                end
                W_RESP: if (s_axi_bready) begin
                    s_axi_bvalid  <= 1'b0;
                    s_axi_awready <= 1'b1;
                    w_state       <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Next beat to present: first beat from AR, else the following one.
    always_comb begin
        ld_idx  = r_idx;
        ld_beat = r_beat;
        ld_len  = r_len;
        r_load  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                ld_idx  = ar_idx;
                ld_beat = '0;
                ld_len  = s_axi_arlen;
                r_load  = ar_fire && (READ_LATENCY == 1);
            end
            R_WAIT: r_load = (lat_cnt == 4'd0);
            R_DATA: begin
                ld_idx  = r_idx + IDX_W'(1);
                ld_beat = r_beat + 8'd1;
                r_load  = s_axi_rready && !s_axi_rlast;
            end
            default: r_load = 1'b0;
        endcase
        ld_ok   = (ld_idx[IDX_W-1:MEM_DEPTH_W] == '0);
        ld_data = ld_ok ? mem[ld_idx[MEM_DEPTH_W-1:0]] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= R_IDLE;
            r_idx         <= '0;
            r_beat        <= '0;
            r_len         <= '0;
            lat_cnt       <= '0;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rresp   <= 2'b00;
        end else begin
            unique case (r_state)
                R_IDLE: if (ar_fire) begin
                    s_axi_rid     <= s_axi_arid;
                    r_len         <= s_axi_arlen;
                    r_idx         <= ar_idx;
                    r_beat        <= '0;
                    lat_cnt       <= LAT_INIT;
                    s_axi_arready <= 1'b0;
                    r_state       <= (READ_LATENCY == 1) ? R_DATA : R_WAIT;
                end
                R_WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd0) r_state <= R_DATA;
                end
                R_DATA: if (s_axi_rready && s_axi_rlast) begin
                    s_axi_rvalid  <= 1'b0;
                    s_axi_rlast   <= 1'b0;
                    s_axi_arready <= 1'b1;
                    r_state       <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
            if (r_load) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= ld_data;
                s_axi_rresp  <= ld_ok ? 2'b00 : 2'b10;
                s_axi_rlast  <= (ld_beat == ld_len);
                r_idx        <= ld_idx;
                r_beat       <= ld_beat;
            end
        end
    end

endmodule

// File: tb/tb_vx_axi_mem_responder.sv
// Bench for vx_axi_mem_responder: vector table of write/read-back
// pairs, scoreboarded R and B channels, hand-written corner sequences.
module tb_vx_axi_mem_responder;

    localparam int DW    = 512;
    localparam int AW    = 32;
    localparam int TW    = 8;
    localparam int MW    = 10;
    localparam int RL    = 3;
    localparam int DEPTH = 1 << MW;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            awvalid, awready;
    logic [AW-1:0]   awaddr;
    logic [TW-1:0]   awid;
    logic [7:0]      awlen;
    logic            wvalid, wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            bvalid, bready;
    logic [TW-1:0]   bid;
    logic [1:0]      bresp;
    logic            arvalid, arready;
    logic [AW-1:0]   araddr;
    logic [TW-1:0]   arid;
    logic [7:0]      arlen;
    logic            rvalid, rready;
    logic [DW-1:0]   rdata;
    logic            rlast;
    logic [TW-1:0]   rid;
    logic [1:0]      rresp;

    vx_axi_mem_responder #(
        .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_TID_WIDTH(TW),
        .MEM_DEPTH_W(MW), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_awaddr(awaddr), .s_axi_awid(awid), .s_axi_awlen(awlen),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_bid(bid), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_araddr(araddr), .s_axi_arid(arid), .s_axi_arlen(arlen),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .s_axi_rdata(rdata), .s_axi_rlast(rlast),
        .s_axi_rid(rid), .s_axi_rresp(rresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
        logic [TW-1:0] id;
    } rbeat_t;

    typedef struct {
        logic [TW-1:0] id;
        logic [1:0]    resp;
    } bexp_t;

    typedef struct {
        logic [31:0] waddr;
        logic [7:0]  wid;
        int          wlen;
        logic [31:0] pat;
        int          sb;
        int          wl;
        logic [1:0]  resp;
        logic [31:0] raddr;
        logic [7:0]  rid;
        int          rlen;
        int          rr;
    } vec_t;

    rbeat_t        exp_r[$];
    bexp_t         exp_b[$];
    logic [DW-1:0] model [0:DEPTH-1];
    int            checks = 0;
    int            failures = 0;
    int            rr_mode = 0;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    function automatic logic [DW-1:0] rnd512();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic wait_ready(input int which, input string name);
        bit got = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if ((which == 0 && awready) || (which == 1 && wready) ||
                (which == 2 && arready)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now(name);
    endtask

    task automatic push_r(input logic [31:0] addr, input logic [7:0] id,
                          input int len);
        int     base;
        rbeat_t e;
        base = int'(addr >> 6);
        for (int b = 0; b <= len; b++) begin
            e.id   = id;
            e.last = (b == len);
            if (base + b < DEPTH) begin
                e.data = model[base + b];
                e.resp = 2'b00;
            end else begin
                e.data = '0;
                e.resp = 2'b10;
            end
            exp_r.push_back(e);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] id,
                            input int len, input logic [31:0] pat,
                            input int sb, input int wl,
                            input logic [1:0] resp, input string tag);
        int              base, idx;
        bit              got;
        logic [DW-1:0]   d;
        logic [DW/8-1:0] st;
        bexp_t           be;
        base    = int'(addr >> 6);
        be.id   = id;
        be.resp = resp;
        exp_b.push_back(be);
        @(posedge clk); #1;
        awvalid = 1'b1; awaddr = addr; awid = id; awlen = 8'(len);
        wait_ready(0, {tag, "_aw"});
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            d      = (pat != 0) ? {16{pat}} : rnd512();
            st     = (b == sb) ? 64'h1 : '1;
            wvalid = 1'b1; wdata = d; wstrb = st;
            wlast  = (wl < 0) ? (b == len) : (b == wl);
            idx    = base + b;
            if (idx < DEPTH)
                for (int k = 0; k < DW / 8; k++)
                    if (st[k]) model[idx][8*k +: 8] = d[8*k +: 8];
            wait_ready(1, {tag, "_w"});
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (exp_b.size() == 0) begin got = 1'b1; break; end
        end
        if (!got) fail_now({tag, "_b"});
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] id,
                           input int len, input string tag);
        int n = 0;
        bit got = 1'b0;
        push_r(addr, id, len);
        @(posedge clk); #1;
        arvalid = 1'b1; araddr = addr; arid = id; arlen = 8'(len);
        wait_ready(2, {tag, "_ar"});
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (rvalid) begin n = t; break; end
        end
        chk({tag, "_latency"}, n, RL);
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk); #1;
            if (exp_r.size() == 0) begin got = 1'b1; break; end
        end
        if (!got) fail_now({tag, "_r_drain"});
    endtask

    initial begin
        rready = 1'b0;
        forever begin
            @(posedge clk); #1;
            rready = (rr_mode == 0) ? 1'b1 : ~rready;
        end
    end

    // R scoreboard plus hold-while-stalled check.
    initial begin
        logic          stall_q = 1'b0;
        logic [DW-1:0] h_data;
        logic [1:0]    h_resp;
        logic          h_last;
        logic [TW-1:0] h_id;
        rbeat_t        e;
        forever begin
            @(negedge clk);
            if (stall_q && rvalid) begin
                chk("r_hold_data", rdata, h_data);
                chk("r_hold_resp", rresp, h_resp);
                chk("r_hold_last", rlast, h_last);
                chk("r_hold_id", rid, h_id);
            end
            stall_q = reset_n && rvalid && !rready;
            h_data = rdata; h_resp = rresp; h_last = rlast; h_id = rid;
            if (reset_n && rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    fail_now("r_unexpected_beat");
                end else begin
                    e = exp_r.pop_front();
                    chk("r_data", rdata, e.data);
                    chk("r_resp", rresp, e.resp);
                    chk("r_last", rlast, e.last);
                    chk("r_id", rid, e.id);
                end
            end
        end
    end

    initial begin
        bexp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    fail_now("b_unexpected");
                end else begin
                    e = exp_b.pop_front();
                    chk("b_id", bid, e.id);
                    chk("b_resp", bresp, e.resp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[9];
        bit   got;
        vt[0] = '{32'h40,   8'd3,  0,  32'hA5A5A5A5, -1, -1, 2'b00,
                  32'h40,   8'd3,  0,  0};
        vt[1] = '{32'h0,    8'd4,  3,  32'h0, -1, -1, 2'b00,
                  32'h0,    8'd4,  3,  0};
        vt[2] = '{32'h0,    8'd5,  3,  32'h0,  2, -1, 2'b00,
                  32'h0,    8'd6,  3,  1};
        vt[3] = '{32'hFF00, 8'd7,  1,  32'h0, -1, -1, 2'b00,
                  32'hFF00, 8'd7,  1,  0};
        vt[4] = '{32'hFF80, 8'd8,  3,  32'h0, -1, -1, 2'b10,
                  32'hFF00, 8'd8,  3,  1};
        vt[5] = '{32'h0,    8'd0,  -1, 32'h0, -1, -1, 2'b00,
                  32'hFF80, 8'd9,  3,  0};
        vt[6] = '{32'h200,  8'd10, 3,  32'h0, -1,  1, 2'b10,
                  32'h200,  8'd10, 3,  1};
        vt[7] = '{32'h1234, 8'd11, 2,  32'h0, -1, -1, 2'b00,
                  32'h1200, 8'd12, 2,  0};
        vt[8] = '{32'h4000, 8'd13, 15, 32'h0, -1, -1, 2'b00,
                  32'h4000, 8'd13, 15, 1};

        reset_n = 1'b0;
        awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        bready = 1'b1;
        arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0;
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 1'b1);
        chk("rst_arready", arready, 1'b1);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, '0);

        // AR pending across release; first accept must wait one edge.
        push_r(32'h0010_0000, 8'h77, 0);
        arvalid = 1'b1; araddr = 32'h0010_0000; arid = 8'h77; arlen = 8'd0;
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk) chk("sync_no_accept", arready, 1'b1);
        @(negedge clk) chk("sync_accept", arready, 1'b0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (exp_r.size() == 0) begin got = 1'b1; break; end
        end
        if (!got) fail_now("sync_r_drain");

        for (int i = 0; i < 9; i++) begin
            if (vt[i].wlen >= 0)
                do_write(vt[i].waddr, vt[i].wid, vt[i].wlen, vt[i].pat,
                         vt[i].sb, vt[i].wl, vt[i].resp,
                         $sformatf("v%0d", i));
            rr_mode = vt[i].rr;
            do_read(vt[i].raddr, vt[i].rid, vt[i].rlen, $sformatf("v%0d", i));
            rr_mode = 0;
        end

        // Concurrent read and write bursts to separate regions.
        do_write(32'h8000, 8'd20, 7, 32'h0, -1, -1, 2'b00, "cc_pre");
        rr_mode = 1;
        fork
            do_write(32'hA000, 8'd21, 7, 32'h0, -1, -1, 2'b00, "cc_w");
            do_read(32'h8000, 8'd22, 7, "cc_r");
        join
        rr_mode = 0;
        do_read(32'hA000, 8'd23, 7, "cc_chk");

        // Reset while beat 3 of an 8-beat read is presented.
        push_r(32'h4000, 8'h31, 7);
        @(posedge clk); #1;
        arvalid = 1'b1; araddr = 32'h4000; arid = 8'h31; arlen = 8'd7;
        wait_ready(2, "rst_ar");
        @(posedge clk); #1;
        arvalid = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (exp_r.size() <= 5) begin got = 1'b1; break; end
        end
        if (!got) fail_now("rst_beat3");
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_rvalid", rvalid, 1'b0);
        chk("midrst_rlast", rlast, 1'b0);
        chk("midrst_rid", rid, '0);
        chk("midrst_rdata", rdata, '0);
        chk("midrst_arready", arready, 1'b1);
        exp_r.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_arready", arready, 1'b1);
        do_read(32'h4000, 8'h32, 7, "rst_reread");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vx_axi_mem_responder.md
VX_AXI_MEM_RESPONDER -- requirements
Module: VX_axi_mem_responder

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 512, data bus width in bits (power of two, >=32).
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter AXI_TID_WIDTH, default 8, transaction ID width.
REQ-004 SHALL have parameter MEM_DEPTH_W, default 10, log2 of backing-store depth in data words.
REQ-005 SHALL have parameter READ_LATENCY, default 2, cycles from AR accept to first rvalid (legal 1..15).
REQ-006 SHALL have ports: clk input 1, sole clock; reset_n input 1, asynchronous active-low reset. The clock is clk. Reset is asynchronous and active-low.
REQ-007 SHALL have AW ports: s_axi_awvalid in 1; s_axi_awready out 1; s_axi_awaddr in AXI_ADDR_WIDTH; s_axi_awid in AXI_TID_WIDTH; s_axi_awlen in 8.
REQ-008 SHALL have W ports: s_axi_wvalid in 1; s_axi_wready out 1; s_axi_wdata in AXI_DATA_WIDTH; s_axi_wstrb in AXI_DATA_WIDTH/8; s_axi_wlast in 1.
REQ-009 SHALL have B ports: s_axi_bvalid out 1; s_axi_bready in 1; s_axi_bid out AXI_TID_WIDTH; s_axi_bresp out 2.
REQ-010 SHALL have AR ports: s_axi_arvalid in 1; s_axi_arready out 1; s_axi_araddr in AXI_ADDR_WIDTH; s_axi_arid in AXI_TID_WIDTH; s_axi_arlen in 8.
REQ-011 SHALL have R ports: s_axi_rvalid out 1; s_axi_rready in 1; s_axi_rdata out AXI_DATA_WIDTH; s_axi_rlast out 1; s_axi_rid out AXI_TID_WIDTH; s_axi_rresp out 2.

Function
REQ-012 SHALL act as AXI4 slave, INCR bursts only, one outstanding write and one outstanding read; write and read paths independent and concurrent.
REQ-013 SHALL compute word index = addr >> log2(AXI_DATA_WIDTH/8); low offset bits ignored; index increments by 1 per beat.
REQ-014 Write FSM SHALL be W_IDLE -> W_DATA (AW fire) -> W_RESP (final beat fire) -> W_IDLE (B fire); awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-015 SHALL latch awid/awlen/index on AW fire; burst ends on the W beat where beat count == awlen, independent of wlast.
REQ-016 SHALL write each W beat byte-wise per wstrb at the cycle of W fire; wstrb=0 leaves word unchanged.
REQ-017 bresp SHALL be 2'b10 (SLVERR) if any beat index >= 2^MEM_DEPTH_W (such beats not written) or wlast disagrees with final-beat position on any beat; else 2'b00; bid = latched awid.
REQ-018 Read FSM SHALL be R_IDLE -> R_WAIT (AR fire) -> R_DATA (latency counter expires) -> R_IDLE (final beat R fire); arready=1 only in R_IDLE.
REQ-019 First rvalid SHALL assert exactly READ_LATENCY cycles after the AR fire cycle; subsequent beats back-to-back while rready=1.
REQ-020 rdata/rid/rresp/rlast SHALL hold stable while rvalid && !rready; rlast=1 only on beat awlen-equivalent (beat == arlen).
REQ-021 Out-of-range read beat SHALL return rdata=0, rresp=2'b10; in-range beats rresp=2'b00 independently per beat.
REQ-022 Read beat SHALL return array contents as of the cycle the beat is first presented; a write to same word in the same cycle is not visible to that beat.
REQ-023 bvalid/rvalid SHALL not depend combinationally on bready/rready.
REQ-024 awlen=0 / arlen=0 SHALL produce single-beat bursts with rlast=1 on the only beat.
REQ-025 Index wrap beyond 2^MEM_DEPTH_W SHALL NOT wrap; treated as out-of-range per REQ-017/021.

Reset
REQ-026 On reset_n=0 (asynchronous, any time incl. mid-burst) SHALL force both FSMs idle, counters 0, awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0.
REQ-027 Backing-store contents SHALL NOT be cleared by reset; in-flight bursts are discarded without response.
REQ-028 Release SHALL be synchronized internally so first AW/AR accept occurs no earlier than 1 cycle after reset_n rises.

Verification
REQ-029 Single write addr=0x40, id=3, len=0, data=0xA5.., strb all-ones, then read same -> bresp=0,bid=3; rdata=0xA5.., rlast=1, rid=3, rvalid exactly READ_LATENCY cycles after AR fire.
REQ-030 Write burst len=3 at 0x0 with wstrb=0x1 on beat 2, rready toggling 1/0 -> read back 4 words, only byte0 of word2 updated, rdata stable during stalls.
REQ-031 Write at index 2^MEM_DEPTH_W-2, len=3 -> bresp=2'b10, words 0..1 of region untouched, last two in-range words written.
REQ-032 wlast asserted on beat 1 of len=3 burst -> burst still consumes 4 beats, bresp=2'b10.
REQ-033 Concurrent AR len=7 and AW len=7 to different regions -> both complete, 8 R beats with rlast on beat 7, one B.
REQ-034 reset_n pulled low during R_DATA beat 3 -> rvalid=0 asynchronously, arready=1 after release, previously written data intact on re-read.
